led_pattern_seq: RTL and testbench
==================================

# led_pattern_seq

Parametrised successor to the 8-LED centre-out shifter: drives a WIDTH-bit LED bank with four selectable symmetric patterns (spread out, converge in, bounce, fill bar). A built-in prescaler sets the step rate, and an enable input freezes the display. It sits directly between the board clock/reset and the LED pins; `step` and `wrap` pulses are exported for chaining or sync.

## Interface
- `WIDTH`, default 8: LED count; even, ≥ 4. Half width H = WIDTH/2.
- `STEP_DIV`, default 1: clock cycles per pattern step; ≥ 1. Prescaler counter width is clog2(STEP_DIV), minimum 1 bit.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: synchronous, active-low; sampled on `clk`.
- `en`  in  1: step enable; when low, the prescaler and LEDs hold.
- `mode`  in  2: pattern select. 0 = OUT, 1 = IN, 2 = BOUNCE, 3 = FILL.
- `led`  out  WIDTH: LED drive, registered.
- `step`  out  1: registered one-cycle pulse, high in each cycle after `led` advanced.
- `wrap`  out  1: registered one-cycle pulse, high in each cycle after `led` was reloaded with a seed by a step.

## Operation
- Seed patterns:
  - CENTER = bits H and H-1 set (00011000 for WIDTH=8); used by OUT, BOUNCE and FILL.
  - OUTER = bits WIDTH-1 and 0 set (10000001); used by IN.
- `act_mode` is the mode in effect. It is loaded from `mode` at reset and at every reload, so a `mode` change mid-sequence takes effect only at the next reload.
- OUT: upper half shifts left by 1 and lower half shifts right by 1, zero fill. When `led` == 0, the next step reloads the seed.
  - WIDTH=8 sequence: 00011000, 00100100, 01000010, 10000001, 00000000, then reload. Period H+1.
- IN: upper half shifts right and lower half shifts left, zero fill. When `led` == 0, the next step reloads.
  - WIDTH=8 sequence: 10000001, 01000010, 00100100, 00011000, 00000000, then reload. Period H+1.
- BOUNCE uses a direction register `dir` (0 = outward, 1 = inward).
  - Outward steps follow OUT.
  - On the step that reaches OUTER, set `dir`=1.
  - Inward steps follow IN.
  - The inward step that would produce CENTER is a reload: `dir` goes to 0 and `act_mode` is resampled.
  - There is never an all-zero state. Period WIDTH-2: 6 for WIDTH=8, 2 for WIDTH=4.
- FILL: upper half becomes (upper<<1)|1 and lower half becomes (lower>>1)|MSB-of-half.
  - WIDTH=8 sequence: 00011000, 00111100, 01111110, 11111111, 00000000, then reload. Period H+1.
- Reload loads the seed of the newly sampled `mode` and clears `dir`. If the new mode is IN, the seed is OUTER.

## Timing
- Reset (`reset`=0 at an edge) sets:
  - `led` = seed of the current `mode` input
  - `act_mode` = `mode`
  - prescaler `cnt` = 0, `dir` = 0
  - `step` = 0, `wrap` = 0
- Reset overrides `en` and all other inputs. Asserting it mid-sequence restarts from the seed on the next cycle.
- Prescaler: while `en`=1, `cnt` increments and wraps at STEP_DIV-1. The advance condition is `en`=1 and `cnt`==STEP_DIV-1.
- When the advance condition holds at an edge:
  - `led` takes its next value at that edge.
  - `step`=1 during the following cycle.
  - `wrap`=1 during the following cycle if that update was a reload.
- Otherwise `step` and `wrap` are 0.
- With STEP_DIV=1 and `en` held high, `led` changes every cycle and `step` stays high.
- `en`=0 holds `cnt`, `led`, `dir` and `act_mode`; `step` and `wrap` are 0.
  - Dropping `en` exactly at terminal count suppresses that step.
  - When `en` is raised again, counting resumes from the held `cnt`.
- Latency: the first advance occurs STEP_DIV enabled cycles after reset release.
- No combinational path from any input to any output.

## Test plan
- OUT basic (WIDTH=8, STEP_DIV=1, mode=0, reset low 2 cycles then high, `en`=1) -> `led` = 18,24,42,81,00,18 hex. `wrap` high only in the cycle `led` returns to 18.
- Bounce (mode=2) -> `led` = 18,24,42,81,42,24,18 repeating, never 00. `wrap` high each time 18 is re-entered from 24.
- Deferred mode change: running OUT, set mode=1 while `led`=42 -> continues 81,00, then reloads 81 (OUTER) with `wrap`=1, then 42,24,18,00.
- FILL with prescaler (STEP_DIV=3, mode=3) -> `led` = 18,3C,7E,FF,00,18, each value held exactly 3 cycles. `step` pulses every 3rd cycle.
- Enable gating (STEP_DIV=3): drop `en` at `cnt`=2 for 5 cycles -> no step, `led` frozen. The step occurs 1 cycle after `en` returns.
- Mid-run reset (WIDTH=4, mode=2, at `led`=1001) -> the next cycle shows `led`=0110 with `step`=`wrap`=0, and bouncing 0110,1001 resumes afterwards.

Source files
------------

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: symmetric LED pattern sequencer with built-in step prescaler.
//
// Drives a WIDTH-bit LED bank with one of four centre-symmetric patterns:
// OUT (spread), IN (converge), BOUNCE (spread then converge) and FILL (bar).
// A prescaler sets the step rate. The selected mode is latched only at reset
// and at each reload, so a mode change takes effect at the end of a sequence.
//
// Ports:
//   clk    in   1      rising-edge clock
//   reset  in   1      synchronous active-low reset
//   en     in   1      step enable; low freezes prescaler and display
//   mode   in   2      pattern select: 0 OUT, 1 IN, 2 BOUNCE, 3 FILL
//   led    out  WIDTH  registered LED drive
//   step   out  1      registered pulse, high the cycle after led advanced
//   wrap   out  1      registered pulse, high the cycle after a reload
module led_pattern_seq #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned STEP_DIV = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] led,
   output logic             step,
   output logic             wrap
);

   localparam int unsigned H  = WIDTH / 2;
   localparam int unsigned CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

   localparam logic [CW-1:0] CNT_LAST = CW'(STEP_DIV - 1);

   localparam logic [1:0] MODE_OUT    = 2'd0;
   localparam logic [1:0] MODE_IN     = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;
   localparam logic [1:0] MODE_FILL   = 2'd3;

   localparam logic [WIDTH-1:0] CENTER = WIDTH'(3) << (H - 1);
   localparam logic [WIDTH-1:0] OUTER  = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};

   logic [WIDTH-1:0] led_q, led_d;
   logic [1:0]       act_mode_q, act_mode_d;
   logic             dir_q, dir_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             step_q, step_d;
   logic             wrap_q, wrap_d;

   logic [H-1:0]     up, lo;
   logic [WIDTH-1:0] out_nxt, in_nxt, fill_nxt;
   logic             adv, reload;

   // Seed loaded at reset and on every reload.
   function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
      return (m == MODE_IN) ? OUTER : CENTER;
   endfunction

   // Half-bank shift candidates for each pattern.
   always_comb begin
      up       = led_q[WIDTH-1:H];
      lo       = led_q[H-1:0];
      out_nxt  = {up[H-2:0], 1'b0, 1'b0, lo[H-1:1]};
      in_nxt   = {1'b0, up[H-1:1], lo[H-2:0], 1'b0};
      // A full bar empties on the next step instead of saturating.
      fill_nxt = (led_q == '1) ? '0 : {up[H-2:0], 1'b1, 1'b1, lo[H-1:1]};
   end

   // Next-state: prescaler, pattern advance, reload and pulse generation.
   always_comb begin
      led_d      = led_q;
      act_mode_d = act_mode_q;
      dir_d      = dir_q;
      cnt_d      = cnt_q;
      step_d     = 1'b0;
      wrap_d     = 1'b0;
      reload     = 1'b0;
      adv        = en && (cnt_q == CNT_LAST);

      if (en) begin
         cnt_d = adv ? '0 : cnt_q + CW'(1);
      end

      if (adv) begin
         step_d = 1'b1;
         if (led_q == '0) begin
            reload = 1'b1;
         end else begin
            unique case (act_mode_q)
               MODE_OUT:  led_d = out_nxt;
               MODE_IN:   led_d = in_nxt;
               MODE_FILL: led_d = fill_nxt;
               MODE_BOUNCE: begin
                  if (!dir_q) begin
                     led_d = out_nxt;
                     if (out_nxt == OUTER) dir_d = 1'b1;
                  end else if (in_nxt == CENTER) begin
                     // Returning to the centre ends a bounce period.
                     reload = 1'b1;
                  end else begin
                     led_d = in_nxt;
                  end
               end
               default: led_d = led_q;
            endcase
         end

         if (reload) begin
            led_d      = seed_of(mode);
            act_mode_d = mode;
            dir_d      = 1'b0;
            wrap_d     = 1'b1;
         end
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         led_q      <= seed_of(mode);
         act_mode_q <= mode;
         dir_q      <= 1'b0;
         cnt_q      <= '0;
         step_q     <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         led_q      <= led_d;
         act_mode_q <= act_mode_d;
         dir_q      <= dir_d;
         cnt_q      <= cnt_d;
         step_q     <= step_d;
         wrap_q     <= wrap_d;
      end
   end

   assign led  = led_q;
   assign step = step_q;
   assign wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed plus randomized checks of led_pattern_seq.
// Three instances (8/1, 8/3, 4/1 for WIDTH/STEP_DIV) are compared every cycle
// against a sequence-index reference model; directed steps add fixed values.
module tb_led_pattern_seq;

   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst   [NI];
   logic       en_s  [NI];
   logic [1:0] md    [NI];
   logic [7:0] led0, led1;
   logic [3:0] led2;
   logic       st    [NI];
   logic       wr    [NI];

   led_pattern_seq #(.WIDTH(8), .STEP_DIV(1)) u_w8d1 (
      .clk(clk), .reset(rst[0]), .en(en_s[0]), .mode(md[0]),
      .led(led0), .step(st[0]), .wrap(wr[0]));
   led_pattern_seq #(.WIDTH(8), .STEP_DIV(3)) u_w8d3 (
      .clk(clk), .reset(rst[1]), .en(en_s[1]), .mode(md[1]),
      .led(led1), .step(st[1]), .wrap(wr[1]));
   led_pattern_seq #(.WIDTH(4), .STEP_DIV(1)) u_w4d1 (
      .clk(clk), .reset(rst[2]), .en(en_s[2]), .mode(md[2]),
      .led(led2), .step(st[2]), .wrap(wr[2]));

   int checks = 0;
   int errors = 0;

   int   wid [NI] = '{8, 8, 4};
   int   dv  [NI] = '{1, 3, 1};
   int   m_act [NI];
   int   m_idx [NI];
   int   m_cnt [NI];
   logic m_step [NI];
   logic m_wrap [NI];

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Pattern at position idx of the sequence for mode m.
   function automatic logic [7:0] pat(input int w, input int m, input int idx);
      int h = w / 2;
      int k;
      logic [7:0] p = 8'h00;
      case (m)
         0: if (idx < h) begin p[h+idx] = 1'b1; p[h-1-idx] = 1'b1; end
         1: if (idx < h) begin p[w-1-idx] = 1'b1; p[idx] = 1'b1; end
         2: begin
            k = (idx < h) ? idx : 2*h - 2 - idx;
            p[h+k] = 1'b1; p[h-1-k] = 1'b1;
         end
         default: if (idx < h) for (int j = h-1-idx; j <= h+idx; j++) p[j] = 1'b1;
      endcase
      return p;
   endfunction

   function automatic int period(input int w, input int m);
      return (m == 2) ? w - 2 : w/2 + 1;
   endfunction

   function automatic logic [7:0] obs_led(input int i);
      case (i)
         0:       return led0;
         1:       return led1;
         default: return {4'h0, led2};
      endcase
   endfunction

   task automatic model_edge();
      for (int i = 0; i < NI; i++) begin
         m_step[i] = 1'b0;
         m_wrap[i] = 1'b0;
         if (!rst[i]) begin
            m_act[i] = int'(md[i]);
            m_idx[i] = 0;
            m_cnt[i] = 0;
         end else if (en_s[i]) begin
            if (m_cnt[i] == dv[i] - 1) begin
               m_cnt[i]  = 0;
               m_step[i] = 1'b1;
               m_idx[i]++;
               if (m_idx[i] == period(wid[i], m_act[i])) begin
                  m_idx[i]  = 0;
                  m_act[i]  = int'(md[i]);
                  m_wrap[i] = 1'b1;
               end
            end else begin
               m_cnt[i]++;
            end
         end
      end
   endtask

   // One clock: model follows the edge, outputs compared on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("led[%0d]", i), obs_led(i), pat(wid[i], m_act[i], m_idx[i]));
         chk($sformatf("step[%0d]", i), 8'(st[i]), 8'(m_step[i]));
         chk($sformatf("wrap[%0d]", i), 8'(wr[i]), 8'(m_wrap[i]));
      end
   endtask

   logic [7:0] outv  [5]  = '{8'h24, 8'h42, 8'h81, 8'h00, 8'h18};
   logic [7:0] defv  [7]  = '{8'h81, 8'h00, 8'h81, 8'h42, 8'h24, 8'h18, 8'h00};
   logic [7:0] bncv  [12] = '{8'h24, 8'h42, 8'h81, 8'h42, 8'h24, 8'h18,
                              8'h24, 8'h42, 8'h81, 8'h42, 8'h24, 8'h18};
   logic [7:0] fillv [6]  = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'h00, 8'h18};

   initial begin
      logic [7:0] frozen;
      int n;
      for (int i = 0; i < NI; i++) begin
         rst[i] = 1'b0; en_s[i] = 1'b1; md[i] = 2'd0;
         m_act[i] = 0; m_idx[i] = 0; m_cnt[i] = 0; m_step[i] = 1'b0; m_wrap[i] = 1'b0;
      end
      md[1] = 2'd3;
      md[2] = 2'd2;
      cycle();
      cycle();
      chk("reset_led", led0, 8'h18);
      chk("reset_step", 8'(st[0]), 8'h00);

      // OUT basic
      rst[0] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("out_seq", led0, outv[k]);
         chk("out_wrap", 8'(wr[0]), (k == 4) ? 8'h01 : 8'h00);
      end

      // Deferred mode change while showing 42
      cycle();
      cycle();
      chk("def_pre", led0, 8'h42);
      md[0] = 2'd1;
      for (int k = 0; k < 7; k++) begin
         cycle();
         chk("def_seq", led0, defv[k]);
         chk("def_wrap", 8'(wr[0]), (k == 2) ? 8'h01 : 8'h00);
      end

      // Bounce: reload from 00 into CENTER, then bounce repeatedly
      md[0] = 2'd2;
      cycle();
      chk("bnc_reload", led0, 8'h18);
      chk("bnc_reload_wrap", 8'(wr[0]), 8'h01);
      for (int k = 0; k < 12; k++) begin
         cycle();
         chk("bnc_seq", led0, bncv[k]);
         chk("bnc_wrap", 8'(wr[0]), (bncv[k] == 8'h18) ? 8'h01 : 8'h00);
      end

      // FILL with STEP_DIV=3
      rst[1] = 1'b1;
      for (int c = 1; c <= 15; c++) begin
         cycle();
         chk("fill_seq", led1, fillv[c/3]);
         chk("fill_step", 8'(st[1]), (c % 3 == 0) ? 8'h01 : 8'h00);
      end

      // Enable gating: drop en at terminal count
      n = 0;
      while (m_cnt[1] != 2 && n < 10) begin cycle(); n++; end
      chk("gate_reach", 8'(m_cnt[1]), 8'd2);
      frozen = pat(8, m_act[1], m_idx[1]);
      en_s[1] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("gate_step", 8'(st[1]), 8'h00);
         chk("gate_led", led1, frozen);
      end
      en_s[1] = 1'b1;
      cycle();
      chk("gate_resume_step", 8'(st[1]), 8'h01);

      // Mid-run reset on WIDTH=4 bounce
      rst[2] = 1'b1;
      n = 0;
      while (m_idx[2] != 1 && n < 10) begin cycle(); n++; end
      chk("w4_at_outer", {4'h0, led2}, 8'h09);
      rst[2] = 1'b0;
      cycle();
      chk("w4_rst_led", {4'h0, led2}, 8'h06);
      chk("w4_rst_step", 8'(st[2]), 8'h00);
      chk("w4_rst_wrap", 8'(wr[2]), 8'h00);
      rst[2] = 1'b1;
      cycle();
      chk("w4_b1", {4'h0, led2}, 8'h09);
      cycle();
      chk("w4_b2", {4'h0, led2}, 8'h06);
      chk("w4_b2_wrap", 8'(wr[2]), 8'h01);

      // Randomized enables, modes and occasional resets
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NI; i++) begin
            en_s[i] = ($urandom_range(3, 0) != 0);
            md[i]   = 2'($urandom_range(3, 0));
            rst[i]  = ($urandom_range(31, 0) != 0);
         end
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
